r2_otf_conv: RTL and testbench
==============================

R2_OTF_CONV -- requirements
Module: r2_otf_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of radix-2 signed digits per result word (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning in_digit is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a digit this cycle.
REQ-006 SHALL have port in_digit, input, 2, an MSDF signed digit: 00=0, 01=+1, 11=-1, 10=invalid.
REQ-007 SHALL have port out_valid, output, 1, meaning out_data holds a completed word.
REQ-008 SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-009 SHALL have port out_data, output, WIDTH+1, the two's-complement integer sum of d_i*2^(WIDTH-1-i), with i=0 the first digit.
REQ-010 SHALL have port err, output, 1, a sticky flag for an invalid digit (see Configuration).

Function
REQ-011 SHALL accept a digit only on in_valid && in_ready.
REQ-012 SHALL use three states: IDLE (no digits yet), ACC (1..WIDTH-1 digits accepted) and DONE (word held).
REQ-013 SHALL assert in_ready in IDLE and ACC only; in_ready SHALL be low in DONE.
REQ-014 SHALL keep registers Q and QM, both WIDTH+1 bits; on the first accepted digit of a word SHALL start them from Q=0 and QM=all-ones (-1).
REQ-015 SHALL update Q and QM on each accepted digit as follows:
- +1: Q<={Q,1}, QM<={Q,0}
- 0: Q<={Q,0}, QM<={QM,1}
- -1: Q<={QM,1}, QM<={QM,0}
- The shift drops the MSB, so widths stay fixed.
REQ-016 SHALL count accepted digits; the WIDTH-th accepted digit SHALL move the state to DONE with out_valid=1 on the next cycle (latency 1 cycle after the last digit).
REQ-017 SHALL drive out_data=Q and hold it stable while out_valid && !out_ready.
REQ-018 SHALL, on out_valid && out_ready, go to IDLE and clear the counter; a new digit is accepted no earlier than the next cycle.
REQ-019 SHALL hold all state unchanged on a cycle with no accepted digit in ACC, i.e. bubbles in the digit stream.
REQ-020 SHALL produce a result in the range -(2^WIDTH-1)..+(2^WIDTH-1), with no overflow possible.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, set state=IDLE, counter=0, Q=0, QM=all-ones, out_valid=0, out_data=0, err=0, and in_ready=1 on the following cycle.
REQ-022 SHALL, on reset mid-word or in DONE, discard the partial or held word with no output.
REQ-023 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-024 SHALL be controlled by the macro R2P_OTF_ERR_EN.
REQ-025 SHALL, when R2P_OTF_ERR_EN is defined:
- an accepted digit 10 sets err=1 the next cycle;
- err stays set until rst;
- the digit is treated as 0.
REQ-026 SHALL, when R2P_OTF_ERR_EN is undefined, treat digit 10 as 0 and tie err to 0.

Structure
REQ-027 SHALL take the digit encodings (DIG_ZERO, DIG_POS, DIG_NEG, DIG_INV) and the state encoding from the shared package r2p_pkg.
REQ-028 SHALL put the combinational one-digit Q/QM update in the sub-module r2_otf_step; r2_otf_conv holds the registers, counter, FSM and handshake.

Verification
REQ-029 SHALL cover these directed scenarios, all with WIDTH=4:
- digits +1,0,-1,+1 -> out_data=5'b00111 (7), out_valid one cycle after the 4th digit.
- digits -1,-1,-1,-1 -> out_data=5'b10001 (-15); digits +1,+1,+1,+1 -> 5'b01111 (15).
- digits +1,-1,-1,-1 with in_valid bubbles between digits -> out_data=5'b00001 (1); bubbles change nothing.
- out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0 throughout; the next word is accepted the cycle after the handshake.
- rst asserted after 2 digits -> no output; next word 0,0,0,+1 -> 5'b00001.
- digit 10 inside a word -> with R2P_OTF_ERR_EN, err=1 sticky and the digit counts as 0; without it, err=0.

Source files
------------

// File: rtl/r2p_pkg.sv
// Shared encodings for the radix-2 on-the-fly converter: MSDF digit codes and FSM states.
package r2p_pkg;

    typedef logic [1:0] digit_t;

    localparam digit_t DIG_ZERO = 2'b00;
    localparam digit_t DIG_POS  = 2'b01;
    localparam digit_t DIG_NEG  = 2'b11;
    localparam digit_t DIG_INV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/r2_otf_step.sv
// One-digit on-the-fly conversion step: next Q/QM from current Q/QM and a signed digit.
// Purely combinational; no handshake of its own.
module r2_otf_step
    import r2p_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] q_i,
    input  logic [WIDTH:0] qm_i,
    input  digit_t         digit_i,
    output logic [WIDTH:0] q_o,
    output logic [WIDTH:0] qm_o
);

    // QM always tracks Q-1, so a negative digit never needs a borrow chain.
    always_comb begin
        q_o  = {q_i[WIDTH-1:0], 1'b0};
        qm_o = {qm_i[WIDTH-1:0], 1'b1};
        case (digit_i)
            DIG_POS: begin
                q_o  = {q_i[WIDTH-1:0], 1'b1};
                qm_o = {q_i[WIDTH-1:0], 1'b0};
            end
            DIG_NEG: begin
                q_o  = {qm_i[WIDTH-1:0], 1'b1};
                qm_o = {qm_i[WIDTH-1:0], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/r2_otf_conv.sv
// MSDF radix-2 signed-digit to two's-complement converter; word valid 1 cycle after last digit,
// in_ready low while a word is held unaccepted. Sticky invalid-digit flag under R2P_OTF_ERR_EN.
module r2_otf_conv
    import r2p_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_digit,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [WIDTH:0] out_data,
    output logic           err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_src;
    logic [WIDTH:0] q_q, q_d, qm_q, qm_d;
    logic [WIDTH:0] q_src, qm_src, q_step, qm_step;
    logic           accept;

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = q_q;
    assign accept    = in_valid && in_ready;

    // The first digit of a word starts from Q=0/QM=-1 regardless of leftovers from the previous word.
    assign q_src   = (state_q == ST_IDLE) ? '0 : q_q;
    assign qm_src  = (state_q == ST_IDLE) ? '1 : qm_q;
    assign cnt_src = (state_q == ST_IDLE) ? '0 : cnt_q;

    r2_otf_step #(.WIDTH(WIDTH)) u_step (
        .q_i     (q_src),
        .qm_i    (qm_src),
        .digit_i (digit_t'(in_digit)),
        .q_o     (q_step),
        .qm_o    (qm_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        qm_d    = qm_q;
        case (state_q)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    q_d   = q_step;
                    qm_d  = qm_step;
                    cnt_d = cnt_src + CW'(1);
                    state_d = (cnt_src == CW'(WIDTH - 1)) ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            qm_q    <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
        end
    end

`ifdef R2P_OTF_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept && (digit_t'(in_digit) == DIG_INV)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_r2_otf_conv.sv
// Directed bench for r2_otf_conv at WIDTH=4; inputs driven 1ns after posedge, outputs checked there too.
module tb_r2_otf_conv;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_digit;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out_data;
    logic         err;

    int vecs = 0;
    int miscompares = 0;

`ifdef R2P_OTF_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    localparam logic [1:0] DZ = 2'b00;
    localparam logic [1:0] DP = 2'b01;
    localparam logic [1:0] DN = 2'b11;
    localparam logic [1:0] DI = 2'b10;

    r2_otf_conv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] d);
        in_valid = 1'b1;
        in_digit = d;
        tick();
        in_valid = 1'b0;
        in_digit = DZ;
    endtask

    task automatic drain(input string tag, input logic [W:0] exp);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
        chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_released"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_digit = DZ; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // +1,0,-1,+1 = 8-2+1 = 7; valid appears right after the 4th digit edge
        put(DP); put(DZ); put(DN);
        chk("w1_not_yet", 32'(out_valid), 32'd0);
        put(DP);
        drain("w1", 5'b00111);

        put(DN); put(DN); put(DN); put(DN);
        drain("w_neg15", 5'b10001);
        put(DP); put(DP); put(DP); put(DP);
        drain("w_pos15", 5'b01111);

        // bubbles between digits: +1,-1,-1,-1 = 1
        put(DP);
        tick(); tick();
        chk("bub_valid", 32'(out_valid), 32'd0);
        chk("bub_ready", 32'(in_ready), 32'd1);
        put(DN);
        tick();
        put(DN);
        tick(); tick(); tick();
        chk("bub_valid2", 32'(out_valid), 32'd0);
        put(DN);
        drain("w_bubble", 5'b00001);

        // backpressure: +1,+1,0,0 = 12 held for 5 cycles; a digit offered while held must be ignored
        put(DP); put(DP); put(DZ); put(DZ);
        in_valid = 1'b1; in_digit = DP;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'd12);
            chk("hold_in_rdy", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hs_in_rdy", 32'(in_ready), 32'd1);
        chk("hs_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        put(DZ); put(DZ); put(DN);
        drain("w_after_hold", 5'b00111);

        // reset mid-word, with a simultaneous digit offered: both discarded
        put(DP); put(DN);
        rst = 1'b1; in_valid = 1'b1; in_digit = DP;
        tick();
        rst = 1'b0; in_valid = 1'b0; in_digit = DZ;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        chk("midrst_in_rdy", 32'(in_ready), 32'd1);
        put(DZ); put(DZ); put(DZ);
        chk("midrst_cnt", 32'(out_valid), 32'd0);
        put(DP);
        drain("w_after_rst", 5'b00001);

        // reset while a word is held discards it
        put(DP); put(DP); put(DP); put(DP);
        chk("donerst_pre", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        chk("donerst_valid", 32'(out_valid), 32'd0);
        chk("donerst_data", 32'(out_data), 32'd0);

        // invalid digit counts as 0: +1,10,-1,+1 = 7
        put(DP);
        chk("err_before", 32'(err), 32'd0);
        put(DI);
        chk("err_set", 32'(err), 32'(ERR_EXP));
        put(DN); put(DP);
        drain("w_inv", 5'b00111);
        chk("err_sticky", 32'(err), 32'(ERR_EXP));
        put(DZ); put(DZ); put(DZ); put(DN);
        drain("w_neg1", 5'b11111);
        chk("err_sticky2", 32'(err), 32'(ERR_EXP));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
